// File: rtl/acc_bank.sv
// acc_bank: bank of DEPTH accumulators with LOAD/ADD/SUB/READ, valid/ready input and clear-all sweep.
// Optional macro ACC_SAT_EN: ADD/SUB clamp on carry/borrow instead of wrapping.
module acc_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_all,
  output logic             out_valid,
  output logic [SEL_W-1:0] out_sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] idx_reg;
  logic             accept;
  logic [DEPTH-1:0] hit;
  logic             sel_ok;
  logic [WIDTH-1:0] acc_val [DEPTH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;
  logic             wr_en;

  // State register and sweep index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == SWEEP) begin
        idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (clr_all) state_next = SWEEP;
      SWEEP:   if (idx_reg == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == IDLE) && !clr_all;
    busy     = (state_reg == SWEEP);
  end

  assign accept = in_valid && in_ready;

  // One-hot decode of the select; out-of-range selects match nothing
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit[gi] = (in_sel == SEL_W'(gi));
    end
  endgenerate

  assign sel_ok = |hit;

  always_comb begin
    cur = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit[i]) cur = acc_val[i];
    end
  end

  assign sum    = {1'b0, cur} + {1'b0, in_data};
  assign diff   = cur - in_data;
  assign borrow = (in_data > cur);

  always_comb begin
    res_next = cur;
    ovf_next = 1'b0;
    case (in_op)
      OP_LOAD: res_next = in_data;
      OP_ADD: begin
        ovf_next = sum[WIDTH];
`ifdef ACC_SAT_EN
        res_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        res_next = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        ovf_next = borrow;
`ifdef ACC_SAT_EN
        res_next = borrow ? '0 : diff;
`else
        res_next = diff;
`endif
      end
      default: res_next = cur;
    endcase
    if (!sel_ok) begin
      res_next = '0;
      ovf_next = 1'b0;
    end
  end

  assign wr_en = accept && sel_ok && (in_op != OP_READ);

  // Sweep clear and a transaction write can never collide: writes need IDLE
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_acc
      logic [WIDTH-1:0] acc_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc_reg <= '0;
        end else if (busy && (idx_reg == SEL_W'(gi))) begin
          acc_reg <= '0;
        end else if (wr_en && hit[gi]) begin
          acc_reg <= res_next;
        end
      end
      assign acc_val[gi] = acc_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_sel  <= in_sel;
        out_data <= res_next;
        out_ovf  <= ovf_next;
      end
    end
  end

endmodule
